regfile_writeback: RTL and testbench
====================================

Name: regfile_writeback

Overview:
- Writeback stage directly downstream of the execute-stage pipeline register.
- Consumes that register's write enable, destination select and ALU result, and commits them into a 32-entry integer register file.
- Serves the two decode-stage source-operand reads, with same-cycle write-to-read bypass.
- Provides a registered writeback echo, used as the second-level forwarding source for hazard handling, plus a retire counter.

Parameters:
- XLEN, 32, data width of registers and result path.
- NUM_REGS, 32, number of architectural registers; x0 is hardwired to zero.
- SEL_W, 5, register select width; must satisfy 2**SEL_W == NUM_REGS.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- write_enable_in  input  1  commit request from the execute-stage register.
- rd_sel_in  input  SEL_W  destination register select.
- rd_value_in  input  XLEN  result to commit (the ALU result).
- rs1_sel  input  SEL_W  decode source 1 select.
- rs2_sel  input  SEL_W  decode source 2 select.
- rs1_value  output  XLEN  source 1 operand, combinational.
- rs2_value  output  XLEN  source 2 operand, combinational.
- wb_write_enable_out  output  1  registered echo: a commit occurred last cycle.
- wb_rd_sel_out  output  SEL_W  registered echo of the committed register select.
- wb_rd_value_out  output  XLEN  registered echo of the committed value.
- retire_count  output  32  number of commit cycles since reset.

Behaviour:
- Reset: when rst=1 at a rising edge:
  - all NUM_REGS entries become 0.
  - wb_write_enable_out=0, wb_rd_sel_out=0, wb_rd_value_out=0, retire_count=0.
  - rst has priority over any concurrent write_enable_in; no write occurs in that cycle.
  - The priority rule is the same when reset asserts in the middle of a run of back-to-back commits.
- Commit condition: commit = write_enable_in && !rst && (rd_sel_in != 0).
- Commit effect: on a commit, regs[rd_sel_in] <= rd_value_in at the rising edge. Write latency is 1 cycle, and the value is architecturally visible in the following cycle.
- x0 writes: a write to x0 (rd_sel_in==0) is discarded. regs[0] reads as 0 at all times, including through the bypass.
- Read path: rsN_value is combinational from rsN_sel and the current inputs, with zero cycles of latency:
  - if rsN_sel==0: the value is 0.
  - else if write_enable_in && !rst && rsN_sel==rd_sel_in: the value is rd_value_in (bypass: write-before-read in the same cycle).
  - else: the value is regs[rsN_sel].
- Both read ports are independent. rs1_sel==rs2_sel==rd_sel_in returns the bypassed value on both ports.
- Echo registers: on every non-reset edge,
  - wb_write_enable_out <= commit.
  - wb_rd_sel_out <= commit ? rd_sel_in : 0.
  - wb_rd_value_out <= commit ? rd_value_in : 0.
  - A write to x0 therefore produces no echo, so downstream forwarding never matches x0.
- retire_count: increments by 1 on each cycle with write_enable_in && !rst, including writes to x0, because the instruction still retires. It is 32-bit unsigned and wraps from 0xFFFFFFFF to 0x00000000 with no flag.
- Back-to-back commits to the same register: the last write wins. The read in each cycle sees that cycle's incoming value via the bypass.
- No X-propagation: registers are never read uninitialised after the first reset.
- Before the first reset, register and output contents are undefined. The bench must apply rst for at least 1 cycle.

Test Plan:
- Reset, then read: rst=1 for 2 cycles with write_enable_in=1, rd_sel_in=5, rd_value_in=0xDEADBEEF -> after release, rs1_sel=5 gives 0, retire_count=0, wb_write_enable_out=0.
- Basic write and read: commit x7=0x12345678 in cycle N; in cycle N+1 set rs2_sel=7 with write_enable_in=0 -> rs2_value=0x12345678; wb_write_enable_out=1, wb_rd_sel_out=7, wb_rd_value_out=0x12345678; retire_count=1.
- Same-cycle bypass: regs[3]=0x11; in one cycle drive write_enable_in=1, rd_sel_in=3, rd_value_in=0x22, rs1_sel=rs2_sel=3 -> both ports read 0x22 combinationally; the next cycle reads 0x22 from storage.
- x0 protection: write_enable_in=1, rd_sel_in=0, rd_value_in=0xFFFFFFFF; rs1_sel=0 -> rs1_value=0 in that cycle and the next; next-cycle wb_write_enable_out=0, wb_rd_sel_out=0; retire_count increments by 1.
- Reset mid-stream: commits to x1..x4 on consecutive cycles, with rst=1 asserted in the cycle of the x3 commit -> x1, x2, x3 all read 0 afterwards; x4 (committed after release) holds its value; retire_count=1.
- Counter wrap: force retire_count to 0xFFFFFFFE via 2 cycles of hierarchical deposit or a long run, then apply 2 commits -> 0xFFFFFFFF, then 0x00000000.

Source files
------------

// File: rtl/regfile_writeback_if.sv
// regfile_writeback_if: commit, operand-read and writeback-echo signals of the writeback stage
interface regfile_writeback_if #(
    parameter int XLEN  = 32,
    parameter int SEL_W = 5
);
    logic             write_enable_in;
    logic [SEL_W-1:0] rd_sel_in;
    logic [XLEN-1:0]  rd_value_in;
    logic [SEL_W-1:0] rs1_sel;
    logic [SEL_W-1:0] rs2_sel;
    logic [XLEN-1:0]  rs1_value;
    logic [XLEN-1:0]  rs2_value;
    logic             wb_write_enable_out;
    logic [SEL_W-1:0] wb_rd_sel_out;
    logic [XLEN-1:0]  wb_rd_value_out;
    logic [31:0]      retire_count;

    modport master (
        output write_enable_in, rd_sel_in, rd_value_in, rs1_sel, rs2_sel,
        input  rs1_value, rs2_value, wb_write_enable_out, wb_rd_sel_out, wb_rd_value_out, retire_count
    );

    modport slave (
        input  write_enable_in, rd_sel_in, rd_value_in, rs1_sel, rs2_sel,
        output rs1_value, rs2_value, wb_write_enable_out, wb_rd_sel_out, wb_rd_value_out, retire_count
    );
endinterface

// File: rtl/regfile_writeback.sv
// regfile_writeback: commits ALU results into the register file, serves bypassed reads, echoes commits
module regfile_writeback #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int SEL_W    = 5
) (
    input logic clk,
    input logic rst,
    regfile_writeback_if.slave bus
);
    logic             retire;
    logic             commit;
    logic [XLEN-1:0]  regs_q [NUM_REGS];
    logic             wb_we_q, wb_we_d;
    logic [SEL_W-1:0] wb_sel_q, wb_sel_d;
    logic [XLEN-1:0]  wb_val_q, wb_val_d;
    logic [31:0]      retire_q, retire_d;

    // x0 writes still retire but never commit, so they leave no echo for forwarding to match
    always_comb begin
        retire   = bus.write_enable_in && !rst;
        commit   = retire && (bus.rd_sel_in != '0);
        wb_we_d  = commit;
        wb_sel_d = commit ? bus.rd_sel_in : '0;
        wb_val_d = commit ? bus.rd_value_in : '0;
        retire_d = retire_q + {31'b0, retire};
    end

    always_comb begin
        bus.rs1_value = (bus.rs1_sel == '0) ? '0 :
                        (retire && bus.rs1_sel == bus.rd_sel_in) ? bus.rd_value_in : regs_q[bus.rs1_sel];
        bus.rs2_value = (bus.rs2_sel == '0) ? '0 :
                        (retire && bus.rs2_sel == bus.rd_sel_in) ? bus.rd_value_in : regs_q[bus.rs2_sel];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            wb_we_q  <= 1'b0;
            wb_sel_q <= '0;
            wb_val_q <= '0;
            retire_q <= '0;
        end else begin
            if (commit) regs_q[bus.rd_sel_in] <= bus.rd_value_in;
            wb_we_q  <= wb_we_d;
            wb_sel_q <= wb_sel_d;
            wb_val_q <= wb_val_d;
            retire_q <= retire_d;
        end
    end

    assign bus.wb_write_enable_out = wb_we_q;
    assign bus.wb_rd_sel_out       = wb_sel_q;
    assign bus.wb_rd_value_out     = wb_val_q;
    assign bus.retire_count        = retire_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: scoreboard-driven checks of commits, bypass, x0, reset priority and counter wrap
module tb_regfile_writeback;
    typedef struct packed {
        logic        we;
        logic [4:0]  sel;
        logic [31:0] val;
    } echo_t;

    logic        clk;
    logic        rst;
    int          tests_run;
    int          tests_failed;
    logic [31:0] model [32];
    logic [31:0] exp_cnt;
    echo_t       sb [$];

    regfile_writeback_if #(.XLEN(32), .SEL_W(5)) bus ();

    regfile_writeback #(.XLEN(32), .NUM_REGS(32), .SEL_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_read(input logic [4:0] sel);
        if (sel == 5'd0) return 32'd0;
        if (bus.write_enable_in && !rst && sel == bus.rd_sel_in) return bus.rd_value_in;
        return model[sel];
    endfunction

    task automatic tick();
        echo_t e;
        logic  c;
        c     = bus.write_enable_in && !rst && bus.rd_sel_in != 5'd0;
        e.we  = c;
        e.sel = c ? bus.rd_sel_in : 5'd0;
        e.val = c ? bus.rd_value_in : 32'd0;
        sb.push_back(e);
        if (rst) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
            exp_cnt = 32'd0;
        end else begin
            if (c) model[bus.rd_sel_in] = bus.rd_value_in;
            if (bus.write_enable_in) exp_cnt = exp_cnt + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic we, input logic [4:0] rd, input logic [31:0] val,
                          input logic [4:0] r1, input logic [4:0] r2);
        bus.write_enable_in = we;
        bus.rd_sel_in       = rd;
        bus.rd_value_in     = val;
        bus.rs1_sel         = r1;
        bus.rs2_sel         = r2;
    endtask

    task automatic test_reset();
        echo_t e;
        rst = 1'b1;
        set_in(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            e = sb.pop_front();
            tests_run++;
            if ({bus.wb_write_enable_out, bus.wb_rd_sel_out, bus.wb_rd_value_out} !== e) begin
                tests_failed++;
                $display("FAIL reset_echo got %h expected %h", {bus.wb_write_enable_out, bus.wb_rd_sel_out, bus.wb_rd_value_out}, e);
            end
        end
        rst = 1'b0;
        set_in(1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
        #1;
        tests_run++;
        if (bus.rs1_value !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_x5 got %h expected 0", bus.rs1_value);
        end
        tests_run++;
        if (bus.retire_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_count got %h expected 0", bus.retire_count);
        end
        tests_run++;
        if (bus.wb_write_enable_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_wb_we got %b expected 0", bus.wb_write_enable_out);
        end
    endtask

    task automatic test_basic();
        echo_t e;
        set_in(1'b1, 5'd7, 32'h12345678, 5'd0, 5'd0);
        tick();
        e = sb.pop_front();
        tests_run++;
        if ({bus.wb_write_enable_out, bus.wb_rd_sel_out, bus.wb_rd_value_out} !== {1'b1, 5'd7, 32'h12345678} ||
            e !== {1'b1, 5'd7, 32'h12345678}) begin
            tests_failed++;
            $display("FAIL basic_echo got %h expected %h", {bus.wb_write_enable_out, bus.wb_rd_sel_out, bus.wb_rd_value_out}, e);
        end
        set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd7);
        #1;
        tests_run++;
        if (bus.rs2_value !== 32'h12345678) begin
            tests_failed++;
            $display("FAIL basic_read got %h expected 12345678", bus.rs2_value);
        end
        tests_run++;
        if (bus.retire_count !== 32'd1) begin
            tests_failed++;
            $display("FAIL basic_count got %0d expected 1", bus.retire_count);
        end
    endtask

    task automatic test_bypass();
        echo_t e;
        set_in(1'b1, 5'd3, 32'h11, 5'd0, 5'd0);
        tick();
        e = sb.pop_front();
        set_in(1'b1, 5'd3, 32'h22, 5'd3, 5'd3);
        #1;
        tests_run++;
        if (bus.rs1_value !== 32'h22 || bus.rs2_value !== 32'h22) begin
            tests_failed++;
            $display("FAIL bypass_same_cycle got %h/%h expected 22/22", bus.rs1_value, bus.rs2_value);
        end
        tick();
        e = sb.pop_front();
        tests_run++;
        if ({bus.wb_write_enable_out, bus.wb_rd_sel_out, bus.wb_rd_value_out} !== e) begin
            tests_failed++;
            $display("FAIL bypass_echo got %h expected %h", {bus.wb_write_enable_out, bus.wb_rd_sel_out, bus.wb_rd_value_out}, e);
        end
        set_in(1'b0, 5'd0, 32'd0, 5'd3, 5'd3);
        #1;
        tests_run++;
        if (bus.rs1_value !== 32'h22) begin
            tests_failed++;
            $display("FAIL bypass_stored got %h expected 22", bus.rs1_value);
        end
    endtask

    task automatic test_x0();
        echo_t       e;
        logic [31:0] cnt0;
        cnt0 = bus.retire_count;
        set_in(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        #1;
        tests_run++;
        if (bus.rs1_value !== 32'd0) begin
            tests_failed++;
            $display("FAIL x0_bypass got %h expected 0", bus.rs1_value);
        end
        tick();
        e = sb.pop_front();
        tests_run++;
        if (bus.wb_write_enable_out !== 1'b0 || bus.wb_rd_sel_out !== 5'd0 || e.we !== 1'b0) begin
            tests_failed++;
            $display("FAIL x0_echo got we=%b sel=%0d expected we=0 sel=0", bus.wb_write_enable_out, bus.wb_rd_sel_out);
        end
        tests_run++;
        if (bus.retire_count !== cnt0 + 32'd1) begin
            tests_failed++;
            $display("FAIL x0_count got %0d expected %0d", bus.retire_count, cnt0 + 32'd1);
        end
        set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        #1;
        tests_run++;
        if (bus.rs1_value !== 32'd0) begin
            tests_failed++;
            $display("FAIL x0_stored got %h expected 0", bus.rs1_value);
        end
    endtask

    task automatic test_reset_midstream();
        echo_t e;
        for (int i = 1; i <= 4; i++) begin
            rst = (i == 3);
            set_in(1'b1, 5'(i), 32'hA0A0_0000 + 32'(i), 5'd0, 5'd0);
            tick();
            e = sb.pop_front();
            tests_run++;
            if ({bus.wb_write_enable_out, bus.wb_rd_sel_out, bus.wb_rd_value_out} !== e) begin
                tests_failed++;
                $display("FAIL midrst_echo%0d got %h expected %h", i, {bus.wb_write_enable_out, bus.wb_rd_sel_out, bus.wb_rd_value_out}, e);
            end
        end
        rst = 1'b0;
        set_in(1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
        #1;
        tests_run++;
        if (bus.rs1_value !== 32'd0 || bus.rs2_value !== 32'd0) begin
            tests_failed++;
            $display("FAIL midrst_x1x2 got %h/%h expected 0/0", bus.rs1_value, bus.rs2_value);
        end
        bus.rs1_sel = 5'd3;
        bus.rs2_sel = 5'd4;
        #1;
        tests_run++;
        if (bus.rs1_value !== 32'd0 || bus.rs2_value !== 32'hA0A0_0004) begin
            tests_failed++;
            $display("FAIL midrst_x3x4 got %h/%h expected 0/a0a00004", bus.rs1_value, bus.rs2_value);
        end
        tests_run++;
        if (bus.retire_count !== 32'd1) begin
            tests_failed++;
            $display("FAIL midrst_count got %0d expected 1", bus.retire_count);
        end
    endtask

    task automatic test_back_to_back();
        echo_t       e;
        logic [31:0] e1, e2;
        for (int i = 0; i < 150; i++) begin
            set_in(($urandom_range(0, 3) != 0), 5'($urandom_range(0, 7)), $urandom(),
                   5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            #1;
            e1 = exp_read(bus.rs1_sel);
            e2 = exp_read(bus.rs2_sel);
            tests_run++;
            if (bus.rs1_value !== e1 || bus.rs2_value !== e2) begin
                tests_failed++;
                $display("FAIL b2b_read%0d got %h/%h expected %h/%h", i, bus.rs1_value, bus.rs2_value, e1, e2);
            end
            tick();
            e = sb.pop_front();
            tests_run++;
            if ({bus.wb_write_enable_out, bus.wb_rd_sel_out, bus.wb_rd_value_out} !== e ||
                bus.retire_count !== exp_cnt) begin
                tests_failed++;
                $display("FAIL b2b_echo%0d got %h cnt %h expected %h cnt %h", i,
                         {bus.wb_write_enable_out, bus.wb_rd_sel_out, bus.wb_rd_value_out}, bus.retire_count, e, exp_cnt);
            end
        end
    endtask

    task automatic test_wrap();
        echo_t e;
        set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        force dut.retire_q = 32'hFFFFFFFE;
        for (int i = 0; i < 2; i++) begin
            tick();
            e = sb.pop_front();
        end
        release dut.retire_q;
        exp_cnt = 32'hFFFFFFFE;
        #1;
        tests_run++;
        if (bus.retire_count !== 32'hFFFFFFFE) begin
            tests_failed++;
            $display("FAIL wrap_preset got %h expected fffffffe", bus.retire_count);
        end
        set_in(1'b1, 5'd9, 32'h99, 5'd0, 5'd0);
        tick();
        e = sb.pop_front();
        tests_run++;
        if (bus.retire_count !== 32'hFFFFFFFF) begin
            tests_failed++;
            $display("FAIL wrap_max got %h expected ffffffff", bus.retire_count);
        end
        tick();
        e = sb.pop_front();
        tests_run++;
        if (bus.retire_count !== 32'h0 || bus.wb_rd_value_out !== e.val) begin
            tests_failed++;
            $display("FAIL wrap_zero got %h val %h expected 0 val %h", bus.retire_count, bus.wb_rd_value_out, e.val);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_cnt      = 32'd0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        test_reset();
        test_basic();
        test_bypass();
        test_x0();
        test_reset_midstream();
        test_back_to_back();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
